// File: rtl/cby_param_ccff.sv
// Parametrised Y connection block with shadow/active configuration chain.
// Optional chain parity check: define CBY_CFG_PARITY_EN.
module cby_param_ccff #(
    parameter int CHAN_W   = 20,
    parameter int NUM_IPIN = 9,
    parameter int MUX_SIZE = 8,
    parameter int STRIDE   = 2,
    parameter int SEL_W    = $clog2(MUX_SIZE),
    parameter int CFG_L    = NUM_IPIN * SEL_W,
    parameter int CNT_W    = $clog2(CFG_L + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              config_enable,
    input  logic              ccff_head,
    input  logic              cfg_commit,
    input  logic [CHAN_W-1:0] chany_bottom_in,
    input  logic [CHAN_W-1:0] chany_top_in,
    output logic [CHAN_W-1:0] chany_bottom_out,
    output logic [CHAN_W-1:0] chany_top_out,
    output logic [NUM_IPIN-1:0] ipin_out,
    output logic              ccff_tail,
    output logic [CNT_W-1:0]  cfg_count,
    output logic              cfg_full,
    output logic              cfg_active_valid,
    output logic              cfg_err,
    output logic              cfg_parity_ok
);

    localparam int MUX_P2 = 1 << SEL_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CFG_L);

    logic [CFG_L-1:0] shadow;
    logic [CFG_L-1:0] active;
    logic             parity_good;
    logic             accept;
    logic             reject;

    assign chany_bottom_out = chany_top_in;
    assign chany_top_out    = chany_bottom_in;

    assign ccff_tail = shadow[CFG_L-1];
    assign cfg_full  = (cfg_count == FULL_CNT);

    assign accept = cfg_commit && cfg_full && !config_enable && parity_good;
    assign reject = cfg_commit && !accept;

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            shadow           <= '0;
            active           <= '0;
            cfg_count        <= '0;
            cfg_active_valid <= 1'b0;
            cfg_err          <= 1'b0;
        end else begin
            if (config_enable)
                shadow <= {shadow[CFG_L-2:0], ccff_head};
            if (accept) begin
                active           <= shadow;
                cfg_active_valid <= 1'b1;
                cfg_count        <= '0;
            end else if (config_enable && !cfg_full) begin
                cfg_count <= cfg_count + CNT_W'(1);
            end
            if (reject)
                cfg_err <= 1'b1;
        end
    end

`ifdef CBY_CFG_PARITY_EN
    logic parity;

    // running XOR of every bit shifted in since reset or last commit
    always_ff @(posedge prog_clk) begin
        if (pReset)
            parity <= 1'b0;
        else if (accept)
            parity <= 1'b0;
        else if (config_enable)
            parity <= parity ^ ccff_head;
    end

    assign parity_good   = !parity;
    assign cfg_parity_ok = !parity;
`else
    assign parity_good   = 1'b1;
    assign cfg_parity_ok = 1'b1;
`endif

    // unused select codes above MUX_SIZE map to constant-zero inputs
    logic [MUX_P2-1:0] mux_in [NUM_IPIN];

    for (genvar gi = 0; gi < NUM_IPIN; gi++) begin : g_ipin
        for (genvar gk = 0; gk < MUX_P2; gk++) begin : g_in
            localparam int T = (gi + (gk / 2) * STRIDE) % CHAN_W;
            if (gk >= MUX_SIZE) begin : g_pad
                assign mux_in[gi][gk] = 1'b0;
            end else if (gk % 2 == 0) begin : g_bot
                assign mux_in[gi][gk] = chany_bottom_in[T];
            end else begin : g_top
                assign mux_in[gi][gk] = chany_top_in[T];
            end
        end

        logic [SEL_W-1:0] sel;
        assign sel = active[gi*SEL_W +: SEL_W];
        assign ipin_out[gi] = cfg_active_valid && mux_in[gi][sel];
    end

endmodule

// File: tb/tb_cby_param_ccff.sv
// Directed bench for cby_param_ccff at default parameters (CFG_L = 27).
module tb_cby_param_ccff;

    localparam int CHAN_W   = 20;
    localparam int NUM_IPIN = 9;
    localparam int CFG_L    = 27;
    localparam int CNT_W    = 5;

    logic                prog_clk = 1'b0;
    logic                pReset = 1'b1;
    logic                config_enable = 1'b0;
    logic                ccff_head = 1'b0;
    logic                cfg_commit = 1'b0;
    logic [CHAN_W-1:0]   chany_bottom_in = '0;
    logic [CHAN_W-1:0]   chany_top_in = '0;
    logic [CHAN_W-1:0]   chany_bottom_out;
    logic [CHAN_W-1:0]   chany_top_out;
    logic [NUM_IPIN-1:0] ipin_out;
    logic                ccff_tail;
    logic [CNT_W-1:0]    cfg_count;
    logic                cfg_full;
    logic                cfg_active_valid;
    logic                cfg_err;
    logic                cfg_parity_ok;

    int n_tests = 0;
    int n_fail  = 0;

    cby_param_ccff dut (
        .prog_clk         (prog_clk),
        .pReset           (pReset),
        .config_enable    (config_enable),
        .ccff_head        (ccff_head),
        .cfg_commit       (cfg_commit),
        .chany_bottom_in  (chany_bottom_in),
        .chany_top_in     (chany_top_in),
        .chany_bottom_out (chany_bottom_out),
        .chany_top_out    (chany_top_out),
        .ipin_out         (ipin_out),
        .ccff_tail        (ccff_tail),
        .cfg_count        (cfg_count),
        .cfg_full         (cfg_full),
        .cfg_active_valid (cfg_active_valid),
        .cfg_err          (cfg_err),
        .cfg_parity_ok    (cfg_parity_ok)
    );

    always #5 prog_clk = ~prog_clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic shift_word(input logic [CFG_L-1:0] w);
        for (int i = CFG_L - 1; i >= 0; i--) begin
            config_enable = 1'b1;
            ccff_head     = w[i];
            step();
        end
        config_enable = 1'b0;
        ccff_head     = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
    endtask

    task automatic do_reset();
        pReset = 1'b1;
        step();
        pReset = 1'b0;
    endtask

    logic [CFG_L-1:0] a_cfg;
    logic [29:0]      stream;

    initial begin
        // reset with arbitrary channel data
        chany_bottom_in = 20'hA5C3B;
        chany_top_in    = 20'h3C96E;
        step();
        step();
        check("ft_top_rst", 32'(chany_top_out), 32'h A5C3B);
        check("ft_bot_rst", 32'(chany_bottom_out), 32'h3C96E);
        pReset = 1'b0;
        #1;
        check("rst_ipin", 32'(ipin_out), 32'h0);
        check("rst_count", 32'(cfg_count), 32'd0);
        check("rst_valid", 32'(cfg_active_valid), 32'd0);
        check("rst_err", 32'(cfg_err), 32'd0);
        check("rst_par", 32'(cfg_parity_ok), 32'd1);
        check("rst_tail", 32'(ccff_tail), 32'd0);

        // IPIN0 sel=5, others sel=0
        shift_word(27'd5);
        check("sh27_cnt", 32'(cfg_count), 32'd27);
        check("sh27_full", 32'(cfg_full), 32'd1);
        check("pre_cmt_ipin", 32'(ipin_out), 32'h0);
        commit();
        check("cmt_valid", 32'(cfg_active_valid), 32'd1);
        check("cmt_cnt", 32'(cfg_count), 32'd0);
        check("cmt_err", 32'(cfg_err), 32'd0);
        chany_top_in    = 20'h00010;
        chany_bottom_in = 20'h00002;
        #1;
        check("ipin_a1", 32'(ipin_out), 32'h003);
        chany_top_in    = 20'hFFFEF;
        chany_bottom_in = 20'hFFFFD;
        #1;
        check("ipin_a2", 32'(ipin_out), 32'h1FC);

        // short shift then commit: rejected
        for (int i = 0; i < 10; i++) begin
            config_enable = 1'b1;
            ccff_head     = 1'b1;
            step();
        end
        config_enable = 1'b0;
        commit();
        check("short_err", 32'(cfg_err), 32'd1);
        check("short_cnt", 32'(cfg_count), 32'd10);
        check("short_ipin", 32'(ipin_out), 32'h1FC);

        // commit while shifting: rejected, then clean commit of shifted data
        do_reset();
        a_cfg = (27'd2 << 6) | (27'd3 << 9) | (27'd6 << 12) | (27'd7 << 24);
        shift_word(a_cfg >> 1);
        config_enable = 1'b1;
        ccff_head     = a_cfg[0];
        cfg_commit    = 1'b1;
        step();
        config_enable = 1'b0;
        cfg_commit    = 1'b0;
        check("cs_err", 32'(cfg_err), 32'd1);
        check("cs_cnt", 32'(cfg_count), 32'd27);
        check("cs_valid", 32'(cfg_active_valid), 32'd0);
        commit();
        check("b_valid", 32'(cfg_active_valid), 32'd1);
        check("b_err_sticky", 32'(cfg_err), 32'd1);
        check("b_cnt", 32'(cfg_count), 32'd0);
        chany_bottom_in = 20'h00410;
        chany_top_in    = 20'h00000;
        #1;
        check("ipin_b1", 32'(ipin_out), 32'h014);
        chany_bottom_in = 20'h00000;
        chany_top_in    = 20'h04020;
        #1;
        check("ipin_b2", 32'(ipin_out), 32'h108);
        chany_bottom_in = 20'h000E3;
        chany_top_in    = 20'h00000;
        #1;
        check("ipin_b3", 32'(ipin_out), 32'h0E3);

        // over-shift: saturating count and chain latency
        do_reset();
        stream = 30'h15A3C96E;
        for (int k = 1; k <= 30; k++) begin
            config_enable = 1'b1;
            ccff_head     = stream[k-1];
            step();
            if (k == 26)
                check("tail_k26", 32'(ccff_tail), 32'd0);
            if (k >= 27)
                check($sformatf("tail_k%0d", k), 32'(ccff_tail),
                      32'(stream[k-27]));
        end
        config_enable = 1'b0;
        check("sat_cnt", 32'(cfg_count), 32'd27);
        check("sat_full", 32'(cfg_full), 32'd1);
        commit();
        check("sat_valid", 32'(cfg_active_valid), 32'd1);

        // reset during a shift clears everything
        for (int i = 0; i < 5; i++) begin
            config_enable = 1'b1;
            ccff_head     = 1'b1;
            step();
        end
        config_enable = 1'b0;
        commit();
        check("mid_err", 32'(cfg_err), 32'd1);
        config_enable   = 1'b1;
        pReset          = 1'b1;
        chany_bottom_in = 20'h5A5A5;
        step();
        pReset        = 1'b0;
        config_enable = 1'b0;
        check("mr_ft", 32'(chany_top_out), 32'h5A5A5);
        check("mr_cnt", 32'(cfg_count), 32'd0);
        check("mr_valid", 32'(cfg_active_valid), 32'd0);
        check("mr_err", 32'(cfg_err), 32'd0);
        check("mr_ipin", 32'(ipin_out), 32'h0);
        check("mr_tail", 32'(ccff_tail), 32'd0);
        check("mr_par", 32'(cfg_parity_ok), 32'd1);

        // odd-weight chain
        shift_word(27'h0000001);
`ifdef CBY_CFG_PARITY_EN
        check("odd_par", 32'(cfg_parity_ok), 32'd0);
        commit();
        check("odd_err", 32'(cfg_err), 32'd1);
        check("odd_valid", 32'(cfg_active_valid), 32'd0);
        check("odd_cnt", 32'(cfg_count), 32'd27);
`else
        check("odd_par", 32'(cfg_parity_ok), 32'd1);
        commit();
        check("odd_err", 32'(cfg_err), 32'd0);
        check("odd_valid", 32'(cfg_active_valid), 32'd1);
        check("odd_cnt", 32'(cfg_count), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
